pc_seq_ras: RTL and testbench
=============================

Name: pc_seq_ras

Overview:
Parametrised program-counter sequencer for the pipelined CPU fetch stage; the next generation of the single PC register.
- Holds the fetch PC and selects the next PC from exception, branch, return, call/jump and sequential sources by fixed priority.
- Supports stall.
- Holds a circular return-address stack (RAS) so returns redirect without waiting for register read.

Parameters:
ADDR_W, 32, PC width in bits
RESET_VEC, 0, PC value after reset and while start_i is low
EXC_VEC, 32'h0000_0080, exception handler address
INC, 4, sequential increment (bytes)
RAS_DEPTH, 4, return-address stack entries (power of two, >=2)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-low
start_i  in  1  run enable; low = synchronous hold at RESET_VEC
pc_write_i  in  1  0 = stall (hold PC) unless a redirect is present
exc_i  in  1  exception redirect
br_taken_i  in  1  resolved taken branch
br_target_i  in  ADDR_W  branch target
jump_i  in  1  unconditional jump
call_i  in  1  jump-and-link: jump plus RAS push
ret_i  in  1  return: pop RAS and redirect
jump_target_i  in  ADDR_W  target for jump/call; fallback target for ret on empty RAS
pc_o  out  ADDR_W  current fetch PC
pc_valid_o  out  1  fetch PC is valid
ras_empty_o  out  1  RAS holds 0 entries
ras_full_o  out  1  RAS holds RAS_DEPTH entries
ras_ovf_o  out  1  sticky: push occurred while full
ras_unf_o  out  1  sticky: ret occurred while empty

Behaviour:
- Reset (rst_i=0, asynchronous):
  - pc_o=RESET_VEC, pc_valid_o=0.
  - RAS count=0, top pointer=0; ras_empty_o=1, ras_full_o=0, ras_ovf_o=0, ras_unf_o=0.
  - Reset mid-operation discards all state immediately.
- start_i=0 at a clock edge:
  - pc_o<=RESET_VEC, pc_valid_o<=0.
  - RAS cleared; sticky flags cleared.
  - All other inputs ignored.
- start_i=1: pc_valid_o<=1, so it rises one cycle after start_i rises. Next PC by strict priority:
  1. exc_i: pc_o<=EXC_VEC; RAS unchanged.
  2. br_taken_i: pc_o<=br_target_i; RAS unchanged.
  3. ret_i:
     - RAS non-empty: pc_o<=top entry; count-1.
     - RAS empty: pc_o<=jump_target_i; ras_unf_o<=1.
  4. call_i: pc_o<=jump_target_i; push (pc_o+INC).
  5. jump_i: pc_o<=jump_target_i.
  6. pc_write_i=0: pc_o holds.
  7. otherwise: pc_o<=pc_o+INC.
- Redirects (1-5) override stall; pc_write_i affects only the sequential case.
- Lower-priority requests in the same cycle are dropped with no side effects.
- call_i and ret_i together: ret wins, no push.
- Arithmetic: pc_o+INC is modulo 2^ADDR_W. pc_o = 2^ADDR_W-INC wraps to 0. No alignment checking; targets are taken verbatim.
- RAS is a circular buffer: top pointer log2(RAS_DEPTH) bits, count 0..RAS_DEPTH.
  - Push: write at top+1; top<=top+1; count saturates at RAS_DEPTH.
  - Push when full: overwrites the oldest entry, ras_ovf_o<=1, count stays RAS_DEPTH.
  - Pop: read top; top<=top-1; count-1.
- ras_empty_o and ras_full_o are registered, derived from the new count, and valid in the same cycle as the updated pc_o.
- Sticky flags clear only on reset or start_i=0.
- Latency: every selection takes effect at the next rising edge. No combinational path from inputs to outputs.

Test Plan:
1. Reset: rst_i=0 asynchronously mid-cycle, then start_i=1 for 4 edges. pc_o=0 at once, then 4,8,12,16. pc_valid_o=0 in reset and 1 after the first edge.
2. Stall/redirect: at pc_o=0x10, pc_write_i=0 for 2 cycles, so pc_o holds 0x10. Then pc_write_i=0 with br_taken_i=1, br_target_i=0x200, so pc_o=0x200 next edge.
3. Priority: exc_i, br_taken_i and call_i in the same cycle. pc_o=0x80, RAS unchanged (ras_empty_o stays 1). Next, br_taken_i plus ret_i: branch target taken, no pop.
4. Call/return: at pc_o=0x40, call to 0x100, then ret. pc_o=0x100, then 0x44; ras_empty_o returns to 1.
5. Overflow: RAS_DEPTH=4, 5 calls from PCs 0x0,0x10,0x20,0x30,0x40 (pushes 0x4..0x44). ras_ovf_o=1 and ras_full_o=1. 4 rets yield 0x44,0x34,0x24,0x14. A 5th ret with jump_target_i=0x300 yields 0x300 and sets ras_unf_o=1.
6. Wrap/start: ADDR_W=8, pc_o=0xFC increments to 0x00. Then start_i=0 for one edge: pc_o=0, flags cleared.

Source files
------------

// File: rtl/pc_seq_ras_if.sv
// Fetch-stage PC sequencer bus: control/target inputs and PC/RAS status outputs.
// Latency: n/a (signal bundle only).
// Backpressure: none; pc_write_i stalls only the sequential advance.
interface pc_seq_ras_if #(
    parameter int ADDR_W = 32
);
    logic              start_i;
    logic              pc_write_i;
    logic              exc_i;
    logic              br_taken_i;
    logic [ADDR_W-1:0] br_target_i;
    logic              jump_i;
    logic              call_i;
    logic              ret_i;
    logic [ADDR_W-1:0] jump_target_i;
    logic [ADDR_W-1:0] pc_o;
    logic              pc_valid_o;
    logic              ras_empty_o;
    logic              ras_full_o;
    logic              ras_ovf_o;
    logic              ras_unf_o;

    // Driver side (pipeline control)
    modport master (
        output start_i, pc_write_i, exc_i, br_taken_i, br_target_i,
               jump_i, call_i, ret_i, jump_target_i,
        input  pc_o, pc_valid_o, ras_empty_o, ras_full_o, ras_ovf_o, ras_unf_o
    );

    // Sequencer side
    modport slave (
        input  start_i, pc_write_i, exc_i, br_taken_i, br_target_i,
               jump_i, call_i, ret_i, jump_target_i,
        output pc_o, pc_valid_o, ras_empty_o, ras_full_o, ras_ovf_o, ras_unf_o
    );
endinterface

// File: rtl/pc_seq_ras.sv
// Fetch PC sequencer: priority next-PC select (exc > branch > ret > call > jump > seq) with circular RAS.
// Latency: every selection lands on pc_o at the next rising edge; all outputs registered.
// Backpressure: pc_write_i=0 holds the PC only in the sequential case; redirects always proceed.
module pc_seq_ras #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(32'h0000_0080),
    parameter int                INC       = 4,
    parameter int                RAS_DEPTH = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    pc_seq_ras_if.slave   bus
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pc_valid_q, pc_valid_d;
    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
    logic [ADDR_W-1:0] ras_d [RAS_DEPTH];
    logic [PTR_W-1:0]  top_q, top_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic [ADDR_W-1:0] pc_inc;
    logic [PTR_W-1:0]  push_ptr;

    // Link address wraps naturally modulo 2^ADDR_W; pushes land one slot above top.
    assign pc_inc   = pc_q + ADDR_W'(INC);
    assign push_ptr = top_q + 1'b1;

    // Next-PC priority select and RAS push/pop; status flags follow the new count.
    always_comb begin
        pc_d       = pc_q;
        pc_valid_d = pc_valid_q;
        ras_d      = ras_q;
        top_d      = top_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        if (!bus.start_i) begin
            pc_d       = RESET_VEC;
            pc_valid_d = 1'b0;
            top_d      = '0;
            cnt_d      = '0;
            ovf_d      = 1'b0;
            unf_d      = 1'b0;
        end else begin
            pc_valid_d = 1'b1;
            if (bus.exc_i) begin
                pc_d = EXC_VEC;
            end else if (bus.br_taken_i) begin
                pc_d = bus.br_target_i;
            end else if (bus.ret_i) begin
                if (cnt_q != '0) begin
                    pc_d  = ras_q[top_q];
                    top_d = top_q - 1'b1;
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // Empty stack: fall back to the resolved target and flag it.
                    pc_d  = bus.jump_target_i;
                    unf_d = 1'b1;
                end
            end else if (bus.call_i) begin
                pc_d            = bus.jump_target_i;
                ras_d[push_ptr] = pc_inc;
                top_d           = push_ptr;
                // When full the push overwrites the oldest entry and count stays put.
                if (cnt_q == DEPTH_C) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else if (bus.jump_i) begin
                pc_d = bus.jump_target_i;
            end else if (bus.pc_write_i) begin
                pc_d = pc_inc;
            end
        end
        empty_d = (cnt_d == '0);
        full_d  = (cnt_d == DEPTH_C);
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_q       <= RESET_VEC;
            pc_valid_q <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
            top_q      <= '0;
            cnt_q      <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
            ras_q      <= ras_d;
            top_q      <= top_d;
            cnt_q      <= cnt_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    assign bus.pc_o        = pc_q;
    assign bus.pc_valid_o  = pc_valid_q;
    assign bus.ras_empty_o = empty_q;
    assign bus.ras_full_o  = full_q;
    assign bus.ras_ovf_o   = ovf_q;
    assign bus.ras_unf_o   = unf_q;
endmodule

// File: tb/tb_pc_seq_ras.sv
// Bench for pc_seq_ras: 32-bit and 8-bit instances share stimulus, each with its own model and scoreboard.
// Latency: expectation pushed at the negedge the inputs are applied, checked after the following posedge.
// Backpressure: none; the monitor pops one expectation per cycle per instance.
module tb_pc_seq_ras;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic rst_v = 1'b1;

    always #5 clk_i = ~clk_i;

    pc_seq_ras_if #(.ADDR_W(32)) b32();
    pc_seq_ras_if #(.ADDR_W(8))  b8();

    pc_seq_ras #(.ADDR_W(32)) u32 (.clk_i(clk_i), .rst_i(rst_i), .bus(b32));
    pc_seq_ras #(.ADDR_W(8))  u8  (.clk_i(clk_i), .rst_i(rst_i), .bus(b8));

    typedef struct {
        logic [31:0] pc;
        logic        v, e, f, o, u;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int total = 0;
    int bad   = 0;

    // Reference model: stack kept as an ordered list, oldest at index 0.
    logic [31:0] m_pc  [2];
    logic        m_vld [2];
    logic        m_ovf [2];
    logic        m_unf [2];
    int          m_cnt [2];
    logic [31:0] m_stk [2][4];

    // Current stimulus
    logic        in_st, in_pw, in_ex, in_br, in_jp, in_cl, in_rt;
    logic [31:0] in_bt, in_jt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k]  = 32'h0;
            m_vld[k] = 1'b0;
            m_ovf[k] = 1'b0;
            m_unf[k] = 1'b0;
            m_cnt[k] = 0;
        end
    endtask

    task automatic model_step(input int k, input logic [31:0] mask);
        logic [31:0] link;
        exp_t e;
        link = (m_pc[k] + 32'd4) & mask;
        if (!rst_v || !in_st) begin
            m_pc[k] = 32'h0; m_vld[k] = 1'b0; m_cnt[k] = 0;
            m_ovf[k] = 1'b0; m_unf[k] = 1'b0;
        end else begin
            m_vld[k] = 1'b1;
            if (in_ex) m_pc[k] = 32'h80 & mask;
            else if (in_br) m_pc[k] = in_bt & mask;
            else if (in_rt) begin
                if (m_cnt[k] > 0) begin
                    m_cnt[k]--;
                    m_pc[k] = m_stk[k][m_cnt[k]];
                end else begin
                    m_pc[k] = in_jt & mask;
                    m_unf[k] = 1'b1;
                end
            end else if (in_cl) begin
                if (m_cnt[k] == 4) begin
                    for (int i = 0; i < 3; i++) m_stk[k][i] = m_stk[k][i+1];
                    m_stk[k][3] = link;
                    m_ovf[k] = 1'b1;
                end else begin
                    m_stk[k][m_cnt[k]] = link;
                    m_cnt[k]++;
                end
                m_pc[k] = in_jt & mask;
            end else if (in_jp) m_pc[k] = in_jt & mask;
            else if (in_pw) m_pc[k] = link;
        end
        e.pc = m_pc[k]; e.v = m_vld[k]; e.e = (m_cnt[k] == 0); e.f = (m_cnt[k] == 4);
        e.o = m_ovf[k]; e.u = m_unf[k];
        if (k == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic drive(input logic st, input logic pw, input logic ex, input logic br,
                         input logic [31:0] bt, input logic jp, input logic cl,
                         input logic rt, input logic [31:0] jt);
        @(negedge clk_i);
        in_st = st; in_pw = pw; in_ex = ex; in_br = br; in_bt = bt;
        in_jp = jp; in_cl = cl; in_rt = rt; in_jt = jt;
        rst_i = rst_v;
        b32.start_i = st; b32.pc_write_i = pw; b32.exc_i = ex; b32.br_taken_i = br;
        b32.br_target_i = bt; b32.jump_i = jp; b32.call_i = cl; b32.ret_i = rt;
        b32.jump_target_i = jt;
        b8.start_i = st; b8.pc_write_i = pw; b8.exc_i = ex; b8.br_taken_i = br;
        b8.br_target_i = bt[7:0]; b8.jump_i = jp; b8.call_i = cl; b8.ret_i = rt;
        b8.jump_target_i = jt[7:0];
        model_step(0, 32'hFFFF_FFFF);
        model_step(1, 32'h0000_00FF);
    endtask

    // Asserts reset between clock edges, checks it acts at once, then holds it two edges.
    task automatic do_reset();
        @(posedge clk_i);
        #3;
        rst_v = 1'b0;
        rst_i = 1'b0;
        #1;
        chk("rst_pc32", b32.pc_o, 32'h0);
        chk("rst_vld32", {31'b0, b32.pc_valid_o}, 32'h0);
        chk("rst_flags32", {28'b0, b32.ras_empty_o, b32.ras_full_o, b32.ras_ovf_o, b32.ras_unf_o}, 32'h8);
        chk("rst_pc8", {24'b0, b8.pc_o}, 32'h0);
        chk("rst_flags8", {27'b0, b8.pc_valid_o, b8.ras_empty_o, b8.ras_full_o, b8.ras_ovf_o, b8.ras_unf_o}, 32'h8);
        model_reset();
        repeat (2) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_v = 1'b1;
    endtask

    // Monitor: one expectation per instance per cycle, compared after the edge settles.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_i);
            #2;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("pc32", b32.pc_o, e.pc);
                chk("vld32", {31'b0, b32.pc_valid_o}, {31'b0, e.v});
                chk("ras32", {28'b0, b32.ras_empty_o, b32.ras_full_o, b32.ras_ovf_o, b32.ras_unf_o},
                    {28'b0, e.e, e.f, e.o, e.u});
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("pc8", {24'b0, b8.pc_o}, e.pc);
                chk("vld8", {31'b0, b8.pc_valid_o}, {31'b0, e.v});
                chk("ras8", {28'b0, b8.ras_empty_o, b8.ras_full_o, b8.ras_ovf_o, b8.ras_unf_o},
                    {28'b0, e.e, e.f, e.o, e.u});
            end
        end
    end

    // Stimulus: directed scenarios, then randomized traffic with a mid-run reset.
    initial begin
        in_st = 0; in_pw = 0; in_ex = 0; in_br = 0; in_jp = 0; in_cl = 0; in_rt = 0;
        in_bt = 0; in_jt = 0;
        b32.start_i = 0; b32.pc_write_i = 0; b32.exc_i = 0; b32.br_taken_i = 0;
        b32.br_target_i = 0; b32.jump_i = 0; b32.call_i = 0; b32.ret_i = 0; b32.jump_target_i = 0;
        b8.start_i = 0; b8.pc_write_i = 0; b8.exc_i = 0; b8.br_taken_i = 0;
        b8.br_target_i = 0; b8.jump_i = 0; b8.call_i = 0; b8.ret_i = 0; b8.jump_target_i = 0;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4; i++) m_stk[k][i] = 32'h0;
        do_reset();

        // Sequential from reset: 4, 8, 12, 16
        repeat (4) drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        // Stall holds 0x10, then branch overrides stall
        repeat (2) drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 32'h200, 0, 0, 0, 0);
        // Priority: exception beats branch and call; branch beats ret
        drive(1, 1, 1, 1, 32'h300, 0, 1, 0, 32'h500);
        drive(1, 1, 0, 1, 32'h240, 0, 0, 1, 32'h600);
        // Call then return from 0x40
        drive(1, 1, 0, 1, 32'h40, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 1, 0, 32'h100);
        drive(1, 1, 0, 0, 0, 0, 0, 1, 32'h700);
        // Overflow with five calls, four good returns, one underflow
        drive(1, 1, 0, 1, 32'h0, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) drive(1, 1, 0, 0, 0, 0, 1, 0, 32'(i * 16));
        repeat (5) drive(1, 1, 0, 0, 0, 0, 0, 1, 32'h300);
        // Wrap at top of address space (8-bit instance), then start low clears
        drive(1, 1, 0, 1, 32'hFC, 0, 0, 0, 0);
        repeat (2) drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 0, 1, 0, 32'h44);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        // 32-bit wrap
        drive(1, 1, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);

        for (int n = 0; n < 600; n++) begin
            if (n == 300) do_reset();
            drive(($urandom % 25) != 0, ($urandom % 4) != 0, ($urandom % 16) == 0,
                  ($urandom % 6) == 0, $urandom, ($urandom % 6) == 0,
                  ($urandom % 3) == 0, ($urandom % 3) == 0, $urandom);
        end

        repeat (3) @(posedge clk_i);
        #3;
        chk("drain", 32'(q0.size() + q1.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
